// File: rtl/bnn_neuron_seq_pkg.sv
// Shared types and constants for the sequential binary neuron.
package bnn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  localparam int unsigned DefNInputs = 32;
  localparam int unsigned DefLanes   = 8;

  // Bias and accumulator must hold every count from 0 up to N inclusive.
  function automatic int unsigned calc_bias_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bnn_neuron_seq_if.sv
// Parameter chain and start/result handshake of one bnn_neuron_seq.
interface bnn_neuron_seq_if #(
  parameter int unsigned N_INPUTS = bnn_pkg::DefNInputs,
  parameter int unsigned BIAS_W   = bnn_pkg::calc_bias_w(N_INPUTS)
);

  logic                setup;
  logic                param_in;
  logic                param_out;
  logic                start;
  logic [N_INPUTS-1:0] inputs;
  logic                busy;
  logic                out_valid;
  logic                axon;
  logic [BIAS_W-1:0]   popcount;

  modport master (
    output setup, param_in, start, inputs,
    input  param_out, busy, out_valid, axon, popcount
  );

  modport slave (
    input  setup, param_in, start, inputs,
    output param_out, busy, out_valid, axon, popcount
  );

endinterface

// File: rtl/bnn_neuron_seq_popcount.sv
// Combinational LANES-bit population count.
module bnn_popcount #(
  parameter int unsigned LANES = 8,
  parameter int unsigned CNT_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] bits_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < LANES; i++) begin
      count_o = count_o + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/bnn_neuron_seq.sv
// Time-multiplexed binary neuron: popcount of weighted inputs, LANES bits per clock.
// Define XNOR_MODE_EN for XNOR (+/-1) weighting instead of AND.
module bnn_neuron_seq import bnn_pkg::*; #(
  parameter int unsigned N_INPUTS = DefNInputs,
  parameter int unsigned LANES    = DefLanes,
  parameter int unsigned BIAS_W   = calc_bias_w(N_INPUTS)
) (
  input logic             clk,
  input logic             reset,
  bnn_neuron_seq_if.slave bus
);

  localparam int unsigned Chunks = N_INPUTS / LANES;
  localparam int unsigned CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam int unsigned PcW    = $clog2(LANES + 1);
  localparam int unsigned ChainW = N_INPUTS + BIAS_W;
  localparam logic [CntW-1:0] LastChunk = CntW'(Chunks - 1);

  state_e state_q, state_d;

  // {bias, weights}: one shift register so the chain shifts toward the bias MSB.
  logic [ChainW-1:0]   chain_q;
  logic [N_INPUTS-1:0] in_q;
  logic [CntW-1:0]     cnt_q;
  logic [BIAS_W-1:0]   acc_q;
  logic [BIAS_W-1:0]   pc_q;
  logic                axon_q;
  logic                valid_q;

  logic [N_INPUTS-1:0] weights;
  logic [BIAS_W-1:0]   bias;
  logic [LANES-1:0]    w_chunk;
  logic [LANES-1:0]    x_chunk;
  logic [LANES-1:0]    lane_bits;
  logic [PcW-1:0]      chunk_cnt;
  logic                shift_en;
  logic                start_acc;

  assign weights = chain_q[N_INPUTS-1:0];
  assign bias    = chain_q[ChainW-1 -: BIAS_W];
  assign w_chunk = weights[cnt_q*LANES +: LANES];
  assign x_chunk = in_q[cnt_q*LANES +: LANES];

`ifdef XNOR_MODE_EN
  assign lane_bits = ~(w_chunk ^ x_chunk);
`else
  assign lane_bits = w_chunk & x_chunk;
`endif

  bnn_popcount #(
    .LANES (LANES),
    .CNT_W (PcW)
  ) u_popcount (
    .bits_i  (lane_bits),
    .count_o (chunk_cnt)
  );

  // Setup takes priority over start; both are only honoured in idle.
  always_comb begin
    shift_en  = (state_q == StIdle) && bus.setup;
    start_acc = (state_q == StIdle) && bus.start && !bus.setup;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_acc) state_d = StAccum;
      StAccum: if (cnt_q == LastChunk) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.param_out = chain_q[ChainW-1];
    bus.out_valid = valid_q;
    bus.axon      = axon_q;
    bus.popcount  = pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
      in_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      pc_q    <= '0;
      axon_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_q == StDone);
      if (shift_en) begin
        chain_q <= {chain_q[ChainW-2:0], bus.param_in};
      end
      if (start_acc) begin
        in_q  <= bus.inputs;
        cnt_q <= '0;
        acc_q <= '0;
      end
      if (state_q == StAccum) begin
        acc_q <= acc_q + BIAS_W'(chunk_cnt);
        if (cnt_q != LastChunk) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (state_q == StDone) begin
        axon_q <= (acc_q > bias);
        pc_q   <= acc_q;
      end
    end
  end

endmodule

// File: tb/tb_bnn_neuron_seq.sv
// Scoreboard bench for bnn_neuron_seq with a bit-level reference model.
module tb_bnn_neuron_seq;
  import bnn_pkg::*;

  localparam int unsigned N   = DefNInputs;
  localparam int unsigned L   = DefLanes;
  localparam int unsigned BW  = calc_bias_w(N);
  localparam int unsigned C   = N / L;
  localparam int unsigned TOT = N + BW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bnn_neuron_seq_if #(.N_INPUTS(N), .BIAS_W(BW)) bus ();

  bnn_neuron_seq #(
    .N_INPUTS (N),
    .LANES    (L),
    .BIAS_W   (BW)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic axon;
    int   pc;
    int   at;
  } exp_t;

  int         checks   = 0;
  int         failures = 0;
  int         edge_cnt = 0;
  exp_t       sb[$];
  exp_t       mon_e;
  logic [TOT-1:0] chain_m;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference: count agreeing/active weighted bits directly from the bit vectors.
  function automatic exp_t model(input logic [TOT-1:0] ch, input logic [N-1:0] x, input int at);
    exp_t r;
    int   cnt = 0;
    int   b;
    for (int i = 0; i < N; i++) begin
`ifdef XNOR_MODE_EN
      cnt += (ch[i] == x[i]) ? 1 : 0;
`else
      cnt += (ch[i] && x[i]) ? 1 : 0;
`endif
    end
    b      = int'(ch[TOT-1:N]);
    r.axon = (cnt > b);
    r.pc   = cnt;
    r.at   = at;
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (edge %0d)", edge_cnt);
      end else begin
        mon_e = sb.pop_front();
        check("axon", 64'(bus.axon), 64'(mon_e.axon));
        check("popcount", 64'(bus.popcount), 64'(mon_e.pc));
        check("latency_edge", 64'(edge_cnt), 64'(mon_e.at));
      end
    end
  end

  // Shift a full vector MSB first; param_out must show the old chain MSB each cycle.
  task automatic load(input logic [TOT-1:0] v);
    for (int i = TOT - 1; i >= 0; i--) begin
      bus.setup    = 1'b1;
      bus.param_in = v[i];
      check("param_out", 64'(bus.param_out), 64'(chain_m[TOT-1]));
      @(posedge clk);
      chain_m = {chain_m[TOT-2:0], v[i]};
      #1;
    end
    bus.setup = 1'b0;
  endtask

  task automatic issue(input logic [N-1:0] x);
    bus.start  = 1'b1;
    bus.inputs = x;
    sb.push_back(model(chain_m, x, edge_cnt + C + 2));
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.inputs = N'($urandom);
  endtask

  task automatic run(input logic [N-1:0] x);
    issue(x);
    repeat (C + 1) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_axon"}, 64'(bus.axon), 64'd0);
    check({tag, "_popcount"}, 64'(bus.popcount), 64'd0);
    check({tag, "_param_out"}, 64'(bus.param_out), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] b;
    logic [N-1:0]  w;
    rst          = 1'b1;
    bus.setup    = 1'b0;
    bus.param_in = 1'b0;
    bus.start    = 1'b0;
    bus.inputs   = '0;
    chain_m      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    repeat (6) begin
      @(posedge clk);
      #1;
      check_idle_outputs("reset_idle");
    end

    load({BW'(15), {N{1'b1}}});
    run(N'(32'h0000_FFFF));
    load({BW'(16), {N{1'b1}}});
    run(N'(32'h0000_FFFF));
`ifdef XNOR_MODE_EN
    load({BW'(31), {N{1'b0}}});
    run('0);
    run({N{1'b1}});
`else
    load({BW'(15), N'(32'h0F0F_0F0F)});
    run({N{1'b1}});
    load({BW'(0), N'(32'h0000_0100)});
    run(N'(32'h0000_0100));
    run(N'(32'h0000_0200));
`endif
    load({BW'((1 << BW) - 1), {N{1'b1}}});
    run({N{1'b1}});

    // Chain passthrough: fresh bits push out the previous bias then weights.
    load({BW'($urandom), N'($urandom)});
    load({BW'($urandom), N'($urandom)});

    // setup together with start in idle: only the shift happens.
    bus.setup    = 1'b1;
    bus.start    = 1'b1;
    bus.param_in = 1'b1;
    @(posedge clk);
    chain_m = {chain_m[TOT-2:0], 1'b1};
    #1;
    bus.setup = 1'b0;
    bus.start = 1'b0;
    check("setup_over_start_busy", 64'(bus.busy), 64'd0);
    repeat (C + 3) @(posedge clk);
    #1;

    // setup toggled while busy must leave the chain untouched.
    issue(N'($urandom));
    repeat (C) begin
      bus.setup    = 1'b1;
      bus.param_in = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bus.setup = 1'b0;
    @(posedge clk);
    #1;
    load({BW'($urandom), N'($urandom)});

    // start re-asserted during accumulation is ignored.
    issue(N'($urandom));
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (C + 4) @(posedge clk);
    #1;

    // Reset two cycles into accumulation aborts without a result.
    load({BW'(6'h3F), N'($urandom)});
    bus.start  = 1'b1;
    bus.inputs = N'($urandom);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    chain_m = '0;
    check_idle_outputs("abort");
    repeat (C + 3) @(posedge clk);
    #1;
    check_idle_outputs("abort_after");

    // Randomised loads and back-to-back evaluations.
    for (int it = 0; it < 24; it++) begin
      if ((it % 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       b = '0;
          1:       b = '1;
          default: b = BW'($urandom_range(0, N + 1));
        endcase
        w = N'($urandom);
        load({b, w});
      end
      run(N'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bnn_neuron_seq.md
Name: bnn_neuron_seq

Overview:
- Parametrised, time-multiplexed successor to the single-cycle 8-input binary neuron.
- Computes popcount(weights AND inputs) over N_INPUTS bits, LANES bits per cycle. Fires `axon` when the count is strictly greater than the programmed bias.
- Weights and bias load through the same daisy-chained serial `setup` / `param_in` / `param_out` chain, so neurons can be cascaded into a layer.
- Adds a start/busy/valid handshake and a synchronous reset.

Parameters:
- N_INPUTS, 32, number of binary inputs (and weights); must be a multiple of LANES.
- LANES, 8, input bits accumulated per clock.
- BIAS_W, $clog2(N_INPUTS+1), width of the bias and accumulator.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- setup  in  1  shift-enable for the parameter chain.
- param_in  in  1  serial parameter bit into the weights LSB.
- param_out  out  1  serial parameter bit out (bias MSB), to the next neuron.
- start  in  1  request an evaluation of `inputs`.
- inputs  in  N_INPUTS  binary activations; sampled only on an accepted start.
- busy  out  1  high while an evaluation is in progress (state != IDLE).
- out_valid  out  1  one-cycle pulse; axon and popcount are valid.
- axon  out  1  neuron output; held until the next out_valid.
- popcount  out  BIAS_W  final accumulator value; held with axon.

Behaviour:
- Reset (sync, active-high):
  - weights=0, bias=0, state=IDLE, chunk counter=0, accumulator=0.
  - axon=0, popcount=0, out_valid=0, busy=0.
  - param_out therefore reads 0.
  - Reset mid-evaluation aborts it; no out_valid is produced.
- Parameter chain:
  - Concatenated shift register {bias[BIAS_W-1:0], weights[N_INPUTS-1:0]}, shifting toward the bias MSB.
  - Each clk with setup=1 in IDLE: weights <= {weights[N-2:0], param_in}; bias <= {bias[BIAS_W-2:0], weights[N-1]}.
  - param_out = bias[BIAS_W-1], combinational from the register.
  - A full load takes N_INPUTS+BIAS_W setup cycles. Bias bits are sent first, MSB first, then weights MSB first.
  - setup is ignored when busy=1; the chain holds its value.
- States: IDLE, ACCUM, DONE. Let C = N_INPUTS/LANES.
  - IDLE:
    - start=1 and setup=0 → capture inputs into an internal register; counter=0; acc=0; go to ACCUM.
    - start and setup both high → setup wins, start is dropped.
  - ACCUM: acc += popcount(w_chunk[k] op in_chunk[k]), where chunk k = bits [k*LANES +: LANES] and k = counter.
    - k == C-1 → go to DONE.
    - Otherwise counter++.
  - DONE: register axon = (acc > bias), unsigned; popcount = acc; out_valid=1 for exactly this cycle; go to IDLE.
- Latency:
  - start accepted at edge 0 → out_valid high after edge C+1 (5 cycles for defaults).
  - Back-to-back: start may be reasserted in the cycle after DONE (IDLE).
  - Throughput is one result per C+2 cycles.
- start while busy is ignored; no queueing.
- Arithmetic:
  - The accumulator never overflows: max = N_INPUTS, which fits in BIAS_W.
  - bias = 2^BIAS_W-1 (≥ N_INPUTS) means the neuron never fires.
  - bias=0 fires when any weighted input is active.
- `inputs` may change freely after the start cycle; the captured copy is used.

Optional Feature:
- Macro: XNOR_MODE_EN.
- Defined: the per-bit op is XNOR(weight, input), giving true ±1 BNN semantics with popcount of agreements.
  - With all-zero weights and all-zero inputs, acc = N_INPUTS.
- Undefined: the per-bit op is AND, matching the existing neuron.
- Ports, latency and the chain are identical in both builds.

Decomposition:
- Shared package bnn_pkg:
  - state enum {IDLE, ACCUM, DONE}.
  - Default N_INPUTS/LANES constants.
  - A clog2-based BIAS_W helper function.
- One natural sub-module: bnn_popcount, a parametrised combinational LANES-bit popcount returning $clog2(LANES+1) bits, instantiated once.

Test Plan (defaults N=32, LANES=8):
- Reset, then hold start=0 → busy=0, out_valid=0, axon=0, param_out=0 indefinitely.
- Shift bias=15 then weights=0xFFFFFFFF (38 setup cycles); start with inputs=0x0000FFFF → out_valid at cycle 5, popcount=16, axon=1.
- Same load with bias=16, same inputs → popcount=16, axon=0.
  - AND build, weights=0x0F0F0F0F, inputs=0xFFFFFFFF, bias=15 → popcount=16, axon=1.
- Chain passthrough: preload a known pattern, shift 38 fresh bits → param_out emits the old bias MSB-first, then the old weights MSB-first.
  - setup pulsed while busy → chain unchanged.
- start reasserted during ACCUM → ignored, exactly one out_valid.
  - Reset asserted at cycle 2 of ACCUM → no out_valid; all outputs 0 next cycle.
- XNOR_MODE_EN build: weights=0, inputs=0, bias=31 → popcount=32, axon=1.
  - weights=0, inputs=0xFFFFFFFF → popcount=0, axon=0.
